// File: rtl/spi_txn_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : spi_txn_sequencer
// Purpose  : Shares one spi_master between two requesters. Grants are
//            round-robin. The owner's multi-byte transaction is fed to
//            spi_master through its en/mosi_data/data_ready handshake.
//            MISO bytes are returned to the owner. A minimum CS-high gap is
//            enforced between transactions.
// Ports    : clk_i, rstn_i          - clock, async active-low reset
//            reqN_i, lenN_i, txdN_i - requester N request level, byte count
//                                     (sampled at grant) and current TX byte
//            gntN_o                 - requester N owns spi_master
//            tx_popN_o              - txdN_i consumed (1-cycle pulse)
//            rx_data_o, rx_validN_o - received byte and its owner strobe
//            doneN_o                - transaction complete (1-cycle pulse)
//            busy_o                 - sequencer not idle
//            spi_en_o, spi_mosi_data_o, spi_miso_data_i, spi_data_ready_i
//                                   - spi_master byte interface
// Revision : 1.0 - initial release
// ============================================================================
module spi_txn_sequencer #(
  parameter int P_LEN_W      = 4,
  parameter int P_GAP_CYCLES = 100
) (
  input  logic               clk_i,
  input  logic               rstn_i,
  input  logic               req0_i,
  input  logic               req1_i,
  input  logic [P_LEN_W-1:0] len0_i,
  input  logic [P_LEN_W-1:0] len1_i,
  input  logic [7:0]         txd0_i,
  input  logic [7:0]         txd1_i,
  output logic               gnt0_o,
  output logic               gnt1_o,
  output logic               tx_pop0_o,
  output logic               tx_pop1_o,
  output logic [7:0]         rx_data_o,
  output logic               rx_valid0_o,
  output logic               rx_valid1_o,
  output logic               done0_o,
  output logic               done1_o,
  output logic               busy_o,
  output logic               spi_en_o,
  output logic [7:0]         spi_mosi_data_o,
  input  logic [7:0]         spi_miso_data_i,
  input  logic               spi_data_ready_i
);

  // Wide enough to hold P_GAP_CYCLES-1, and at least one bit when the gap is 1.
  localparam int c_GAP_W = $clog2(P_GAP_CYCLES + 1);
  localparam logic [c_GAP_W-1:0] c_GAP_LOAD = c_GAP_W'(P_GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_XFER = 2'd1,
    S_GAP  = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic                 pref_q, pref_d;    // requester favoured on a tie
  logic [P_LEN_W-1:0]   cnt_q, cnt_d;      // bytes still to complete
  logic [c_GAP_W-1:0]   gap_q, gap_d;
  logic                 gnt0_q, gnt0_d;
  logic                 gnt1_q, gnt1_d;
  logic                 pop0_q, pop0_d;
  logic                 pop1_q, pop1_d;
  logic [7:0]           rx_data_q, rx_data_d;
  logic                 rxv0_q, rxv0_d;
  logic                 rxv1_q, rxv1_d;
  logic                 done0_q, done0_d;
  logic                 done1_q, done1_d;
  logic                 spi_en_q, spi_en_d;
  logic [7:0]           mosi_q, mosi_d;

  logic                 w_pick;            // 1 selects requester 1 in IDLE
  logic [P_LEN_W-1:0]   w_len_sel;
  logic [7:0]           w_txd_own;

  // Tie goes to pref_q; a lone request wins outright.
  assign w_pick    = (req0_i && req1_i) ? pref_q : req1_i;
  assign w_len_sel = w_pick ? len1_i : len0_i;
  // Owner identity is carried by the grant flops themselves.
  assign w_txd_own = gnt1_q ? txd1_i : txd0_i;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q   <= S_IDLE;
      pref_q    <= 1'b0;
      cnt_q     <= '0;
      gap_q     <= '0;
      gnt0_q    <= 1'b0;
      gnt1_q    <= 1'b0;
      pop0_q    <= 1'b0;
      pop1_q    <= 1'b0;
      rx_data_q <= 8'h00;
      rxv0_q    <= 1'b0;
      rxv1_q    <= 1'b0;
      done0_q   <= 1'b0;
      done1_q   <= 1'b0;
      spi_en_q  <= 1'b0;
      mosi_q    <= 8'h00;
    end else begin
      state_q   <= state_d;
      pref_q    <= pref_d;
      cnt_q     <= cnt_d;
      gap_q     <= gap_d;
      gnt0_q    <= gnt0_d;
      gnt1_q    <= gnt1_d;
      pop0_q    <= pop0_d;
      pop1_q    <= pop1_d;
      rx_data_q <= rx_data_d;
      rxv0_q    <= rxv0_d;
      rxv1_q    <= rxv1_d;
      done0_q   <= done0_d;
      done1_q   <= done1_d;
      spi_en_q  <= spi_en_d;
      mosi_q    <= mosi_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pref_d    = pref_q;
    cnt_d     = cnt_q;
    gap_d     = gap_q;
    gnt0_d    = gnt0_q;
    gnt1_d    = gnt1_q;
    rx_data_d = rx_data_q;
    spi_en_d  = spi_en_q;
    mosi_d    = mosi_q;
    // Strobes are single-cycle unless re-asserted below.
    pop0_d    = 1'b0;
    pop1_d    = 1'b0;
    rxv0_d    = 1'b0;
    rxv1_d    = 1'b0;
    done0_d   = 1'b0;
    done1_d   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (req0_i || req1_i) begin
          gnt0_d  = ~w_pick;
          gnt1_d  = w_pick;
          cnt_d   = w_len_sel;
          mosi_d  = w_pick ? txd1_i : txd0_i;
          pref_d  = ~w_pick;
          state_d = S_XFER;
          // A zero-length request consumes no byte.
          if (w_len_sel != '0) begin
            pop0_d = ~w_pick;
            pop1_d = w_pick;
          end
        end
      end

      S_XFER: begin
        if (cnt_q == '0) begin
          // Zero-length transaction: complete without touching the bus
          // and without a CS-high gap.
          done0_d = gnt0_q;
          done1_d = gnt1_q;
          gnt0_d  = 1'b0;
          gnt1_d  = 1'b0;
          state_d = S_IDLE;
        end else if (!spi_en_q) begin
          // First cycle after the grant: first byte is already on mosi.
          spi_en_d = 1'b1;
        end else if (spi_data_ready_i) begin
          rx_data_d = spi_miso_data_i;
          rxv0_d    = gnt0_q;
          rxv1_d    = gnt1_q;
          cnt_d     = cnt_q - P_LEN_W'(1);
          if (cnt_q > P_LEN_W'(1)) begin
            // More bytes: keep CS low and queue the next byte.
            mosi_d = w_txd_own;
            pop0_d = gnt0_q;
            pop1_d = gnt1_q;
          end else begin
            spi_en_d = 1'b0;
            done0_d  = gnt0_q;
            done1_d  = gnt1_q;
            gnt0_d   = 1'b0;
            gnt1_d   = 1'b0;
            gap_d    = c_GAP_LOAD;
            state_d  = S_GAP;
          end
        end
      end

      S_GAP: begin
        if (gap_q == '0) begin
          state_d = S_IDLE;
        end else begin
          gap_d = gap_q - c_GAP_W'(1);
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign gnt0_o          = gnt0_q;
  assign gnt1_o          = gnt1_q;
  assign tx_pop0_o       = pop0_q;
  assign tx_pop1_o       = pop1_q;
  assign rx_data_o       = rx_data_q;
  assign rx_valid0_o     = rxv0_q;
  assign rx_valid1_o     = rxv1_q;
  assign done0_o         = done0_q;
  assign done1_o         = done1_q;
  assign busy_o          = (state_q != S_IDLE);
  assign spi_en_o        = spi_en_q;
  assign spi_mosi_data_o = mosi_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_txn_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_txn_sequencer
// Purpose  : Self-checking bench for spi_txn_sequencer. A byte-level
//            spi_master stand-in, two requester drivers and a
//            transaction-level reference model of arbitration, gap timing
//            and data routing.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_txn_sequencer;

  localparam int LW  = 4;
  localparam int GAP = 12;

  logic            clk;
  logic            rstn;
  logic [1:0]      req_v;
  logic [LW-1:0]   len_v [2];
  logic [7:0]      txd_v [2];
  logic [7:0]      miso;
  logic            rdy;
  logic            gnt0, gnt1, pop0, pop1, rxv0, rxv1, done0, done1, busy, en;
  logic [7:0]      rxd, mosi;

  spi_txn_sequencer #(.P_LEN_W(LW), .P_GAP_CYCLES(GAP)) dut (
    .clk_i(clk), .rstn_i(rstn),
    .req0_i(req_v[0]), .req1_i(req_v[1]),
    .len0_i(len_v[0]), .len1_i(len_v[1]),
    .txd0_i(txd_v[0]), .txd1_i(txd_v[1]),
    .gnt0_o(gnt0), .gnt1_o(gnt1),
    .tx_pop0_o(pop0), .tx_pop1_o(pop1),
    .rx_data_o(rxd), .rx_valid0_o(rxv0), .rx_valid1_o(rxv1),
    .done0_o(done0), .done1_o(done1), .busy_o(busy),
    .spi_en_o(en), .spi_mosi_data_o(mosi),
    .spi_miso_data_i(miso), .spi_data_ready_i(rdy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- bookkeeping ----------------
  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d", nm, act, act, exp, exp, cyc);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // requester stimulus state
  logic [7:0] tx_mem [2][1024];
  int  idx [2];
  int  jobs [2];
  bit  hold [2];
  int  dly [2];
  bit  rnd_dly;
  bit  spur_en;
  int  lenq0[$];
  int  lenq1[$];

  // reference model state
  bit  mon_en;
  bit  m_idle;
  int  m_last, m_owner, m_len, m_left, m_pops, m_gcyc, free_at, m_expect;
  int  mptr [2];
  bit  prev_g [2];
  bit  prev_en, seen_end;
  int  en_low, inv_err, en_rises;
  int  cnt_pop [2], cnt_rx [2], cnt_done [2], done_cyc [2], grant_cyc [2];
  int  glog[$];
  logic [7:0] exp_mosi[$], miso_sent[$], slave_q[$], rx_log[$], mosi_log[$];

  function automatic int next_len(input int i);
    if (i == 0 && lenq0.size() > 0) return lenq0.pop_front();
    if (i == 1 && lenq1.size() > 0) return lenq1.pop_front();
    return ($urandom_range(0, 9) == 0) ? 15 : int'($urandom_range(0, 5));
  endfunction

  task automatic model_reset();
    m_idle = 1'b1; m_last = 1; free_at = 0; m_expect = -1;
    exp_mosi.delete(); miso_sent.delete(); slave_q.delete();
    mptr[0] = idx[0]; mptr[1] = idx[1];
    seen_end = 1'b0; en_low = 0;
  endtask

  // ---------------- requester drivers ----------------
  initial begin
    req_v = 2'b00;
    for (int i = 0; i < 2; i++) begin
      len_v[i] = '0; idx[i] = 0; jobs[i] = 0; hold[i] = 0; dly[i] = 0;
      for (int k = 0; k < 1024; k++) tx_mem[i][k] = 8'($urandom);
      txd_v[i] = tx_mem[i][0];
    end
    forever begin
      @(posedge clk);
      #2;
      for (int i = 0; i < 2; i++) begin
        automatic bit p = (i == 0) ? pop0 : pop1;
        automatic bit d = (i == 0) ? done0 : done1;
        if (!rstn) begin
          req_v[i] = 1'b0;
        end else begin
          if (p) idx[i]++;
          if (d) begin
            jobs[i]--;
            if (hold[i] && jobs[i] > 0) len_v[i] = LW'(next_len(i));
            else begin
              req_v[i] = 1'b0;
              dly[i] = rnd_dly ? int'($urandom_range(0, 15)) : 0;
            end
          end else if (!req_v[i] && jobs[i] > 0) begin
            if (dly[i] > 0) dly[i]--;
            else begin
              len_v[i] = LW'(next_len(i));
              req_v[i] = 1'b1;
            end
          end
        end
        txd_v[i] = tx_mem[i][idx[i] % 1024];
      end
    end
  end

  // ---------------- spi_master stand-in (byte level) ----------------
  initial begin
    automatic bit active = 0;
    automatic int lat = 0;
    rdy = 1'b0; miso = 8'h00;
    forever begin
      @(posedge clk);
      #2;
      if (!rstn) begin
        active = 0; rdy = 1'b0;
      end else begin
        if (rdy) rdy = 1'b0;
        if (!active && en) begin
          active = 1; lat = int'($urandom_range(3, 8));
          mosi_log.push_back(mosi);
          if (mon_en) begin
            chk("mosi_expected", int'(exp_mosi.size() > 0), 1);
            if (exp_mosi.size() > 0) chk("mosi_byte", int'(mosi), int'(exp_mosi.pop_front()));
          end
        end else if (active) begin
          if (!en) active = 0;
          else begin
            lat--;
            if (lat == 0) begin
              active = 0; rdy = 1'b1;
              miso = (slave_q.size() > 0) ? slave_q.pop_front() : 8'($urandom);
              miso_sent.push_back(miso);
            end
          end
        end else if (spur_en && !en && !gnt0 && !gnt1 && $urandom_range(0, 7) == 0) begin
          rdy = 1'b1; miso = 8'($urandom);   // stray strobe, must be ignored
        end
      end
    end
  end

  // ---------------- reference model / monitor ----------------
  initial begin
    automatic int sg, id;
    automatic bit exp_done, sd, exp_busy;
    forever begin
      @(negedge clk);
      if (mon_en && rstn) begin
        sg = (gnt0 && !prev_g[0]) ? 0 : ((gnt1 && !prev_g[1]) ? 1 : -1);
        if (m_expect != -1 || sg != -1) chk("grant_id", sg, m_expect);
        if (sg != -1) begin
          m_idle = 0; m_owner = sg; m_len = int'(len_v[sg]); m_left = m_len;
          m_pops = 0; m_gcyc = cyc; m_last = sg; grant_cyc[sg] = cyc;
          glog.push_back(sg);
          for (int k = 0; k < m_len; k++) exp_mosi.push_back(tx_mem[sg][(mptr[sg] + k) % 1024]);
          mptr[sg] += m_len;
        end
        if (gnt0 && gnt1) inv_err++;
        if (pop0 && pop1) inv_err++;
        if (rxv0 && rxv1) inv_err++;
        if (done0 && done1) inv_err++;
        if (pop0 || pop1) begin
          id = pop1 ? 1 : 0;
          cnt_pop[id]++;
          if (m_idle || id != m_owner) inv_err++;
          else m_pops++;
        end
        exp_done = 0;
        if (rxv0 || rxv1) begin
          id = rxv1 ? 1 : 0;
          cnt_rx[id]++;
          rx_log.push_back(rxd);
          if (m_idle || id != m_owner || m_left == 0 || miso_sent.size() == 0) inv_err++;
          else begin
            chk("rx_data", int'(rxd), int'(miso_sent.pop_front()));
            m_left--;
            if (m_left == 0) exp_done = 1;
          end
        end
        if (!m_idle && m_len == 0 && cyc == m_gcyc + 1) exp_done = 1;
        sd = done0 || done1;
        if (exp_done || sd) begin
          chk("done_time", int'(sd), int'(exp_done));
          if (sd) chk("done_owner", done1 ? 1 : 0, m_owner);
        end
        if (sd) begin
          cnt_done[done1 ? 1 : 0]++;
          done_cyc[done1 ? 1 : 0] = cyc;
        end
        if (exp_done) begin
          m_idle = 1;
          chk("pops_per_txn", m_pops, m_len);
          chk("gnt_drop_at_done", int'(gnt0 | gnt1), 0);
          free_at = (m_len == 0) ? cyc + 1 : cyc + GAP + 1;
        end
        exp_busy = !m_idle || (cyc + 1 < free_at);
        if (busy !== exp_busy) inv_err++;
        if (en && m_idle) inv_err++;
        if (en && !prev_en) begin
          en_rises++;
          if (seen_end) chk("cs_high_gap", int'(en_low >= GAP), 1);
          en_low = 0;
        end
        if (!en) en_low++;
        if (!en && prev_en) seen_end = 1;
        m_expect = -1;
        if (m_idle && cyc + 1 >= free_at && req_v != 2'b00)
          m_expect = (req_v == 2'b11) ? ((m_last == 0) ? 1 : 0) : (req_v[0] ? 0 : 1);
      end
      prev_g[0] = gnt0; prev_g[1] = gnt1; prev_en = en;
    end
  end

  // ---------------- helpers ----------------
  task automatic wait_quiet(input string nm, input int budget);
    int t = 0;
    while (!(jobs[0] == 0 && jobs[1] == 0 && m_idle && !busy && cyc + 1 >= free_at) && t < budget) begin
      @(negedge clk);
      #1;
      t++;
    end
    chk(nm, int'(t < budget), 1);
    repeat (2) @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0; mon_en = 0;
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    model_reset();
    mon_en = 1;
  endtask

  typedef struct {
    int             id;
    int             len;
    logic [2:0][7:0] tx;
    logic [2:0][7:0] rx;
    int             e_pop;
    int             e_rx;
    int             e_done;
    int             e_en;
  } vec_t;

  vec_t tv [4];

  // ---------------- main sequence ----------------
  initial begin
    int s_pop, s_rx, s_done, s_en, t, bad;
    rstn = 1'b0; mon_en = 0; rnd_dly = 0; spur_en = 0; inv_err = 0; en_rises = 0;
    prev_en = 0; prev_g[0] = 0; prev_g[1] = 0;
    for (int i = 0; i < 2; i++) begin
      cnt_pop[i] = 0; cnt_rx[i] = 0; cnt_done[i] = 0; done_cyc[i] = 0; grant_cyc[i] = 0;
    end
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_gnt", int'({gnt1, gnt0}), 0);
    chk("rst_strobes", int'({pop1, pop0, rxv1, rxv0, done1, done0}), 0);
    chk("rst_spi_en", int'(en), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_data", int'({rxd, mosi}), 0);
    @(negedge clk);
    rstn = 1'b1;
    model_reset();
    mon_en = 1;

    // directed single transactions
    tv[0] = '{id: 0, len: 1, tx: {8'h00, 8'h00, 8'hD2}, rx: {8'h00, 8'h00, 8'hA2}, e_pop: 1, e_rx: 1, e_done: 1, e_en: 1};
    tv[1] = '{id: 0, len: 3, tx: {8'hC2, 8'h81, 8'hD2}, rx: {8'h5A, 8'h18, 8'hA2}, e_pop: 3, e_rx: 3, e_done: 1, e_en: 1};
    tv[2] = '{id: 1, len: 0, tx: {8'h00, 8'h00, 8'h77}, rx: {8'h00, 8'h00, 8'h00}, e_pop: 0, e_rx: 0, e_done: 1, e_en: 0};
    tv[3] = '{id: 1, len: 2, tx: {8'h00, 8'hE7, 8'h3C}, rx: {8'h00, 8'h01, 8'h99}, e_pop: 2, e_rx: 2, e_done: 1, e_en: 1};
    for (int v = 0; v < 4; v++) begin
      automatic int i = tv[v].id;
      s_pop = cnt_pop[i]; s_rx = cnt_rx[i]; s_done = cnt_done[i]; s_en = en_rises;
      rx_log.delete(); mosi_log.delete();
      for (int k = 0; k < tv[v].len; k++) begin
        tx_mem[i][(idx[i] + k) % 1024] = tv[v].tx[k];
        slave_q.push_back(tv[v].rx[k]);
      end
      if (i == 0) lenq0.push_back(tv[v].len); else lenq1.push_back(tv[v].len);
      jobs[i] = 1;
      wait_quiet($sformatf("vec%0d_complete", v), 2000);
      chk($sformatf("vec%0d_pops", v), cnt_pop[i] - s_pop, tv[v].e_pop);
      chk($sformatf("vec%0d_rx_valids", v), cnt_rx[i] - s_rx, tv[v].e_rx);
      chk($sformatf("vec%0d_dones", v), cnt_done[i] - s_done, tv[v].e_done);
      chk($sformatf("vec%0d_en_bursts", v), en_rises - s_en, tv[v].e_en);
      chk($sformatf("vec%0d_rx_count", v), rx_log.size(), tv[v].len);
      chk($sformatf("vec%0d_mosi_count", v), mosi_log.size(), tv[v].len);
      for (int k = 0; k < tv[v].len && k < rx_log.size() && k < mosi_log.size(); k++) begin
        chk($sformatf("vec%0d_rx%0d", v, k), int'(rx_log[k]), int'(tv[v].rx[k]));
        chk($sformatf("vec%0d_mosi%0d", v, k), int'(mosi_log[k]), int'(tv[v].tx[k]));
      end
    end
    chk("invariants_directed", inv_err, 0);

    // simultaneous held requests after reset: RR starts with requester 0
    do_reset();
    hold[0] = 1; hold[1] = 1;
    lenq0.push_back(2); lenq0.push_back(2);
    lenq1.push_back(2); lenq1.push_back(2);
    glog.delete();
    jobs[0] = 2; jobs[1] = 2;
    wait_quiet("rr_complete", 3000);
    chk("rr_grants", glog.size(), 4);
    for (int k = 0; k < 4 && k < glog.size(); k++) chk($sformatf("rr_order%0d", k), glog[k], k % 2);
    hold[0] = 0; hold[1] = 0;

    // late request from requester 1 during requester 0's transaction
    lenq0.push_back(3);
    jobs[0] = 1;
    t = 0;
    while (!gnt0 && t < 500) begin @(negedge clk); #1; t++; end
    chk("late_req_gnt0_seen", int'(t < 500), 1);
    lenq1.push_back(1);
    jobs[1] = 1;
    wait_quiet("late_req_complete", 3000);
    chk("regrant_distance", grant_cyc[1] - done_cyc[0], GAP + 1);
    chk("invariants_rr", inv_err, 0);

    // reset in the middle of the second byte of a 3-byte transfer
    lenq0.push_back(3);
    s_done = cnt_done[0];
    jobs[0] = 1;
    t = 0;
    while (!(en && cnt_rx[0] > 0 && cnt_done[0] == s_done) && t < 1000) begin @(negedge clk); #1; t++; end
    chk("midrst_reached", int'(t < 1000), 1);
    s_rx = cnt_rx[0];
    while (!(en && cnt_rx[0] == s_rx + 1) && t < 1000) begin @(negedge clk); #1; t++; end
    @(posedge clk);
    #3;
    rstn = 1'b0; mon_en = 0;
    #1;
    chk("midrst_spi_en", int'(en), 0);
    chk("midrst_gnt", int'({gnt1, gnt0}), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_data", int'({rxd, mosi}), 0);
    bad = 0;
    repeat (4) begin
      @(negedge clk);
      if (done0 || done1 || rxv0 || rxv1 || pop0 || pop1 || en) bad++;
    end
    jobs[0] = 0;
    rstn = 1'b1;
    #1;
    model_reset();
    mon_en = 1;
    @(negedge clk);
    if (done0 || done1 || rxv0 || rxv1) bad++;
    chk("midrst_no_strobes", bad, 0);
    s_done = cnt_done[0]; s_rx = cnt_rx[0];
    lenq0.push_back(1);
    jobs[0] = 1;
    wait_quiet("post_rst_complete", 2000);
    chk("post_rst_done", cnt_done[0] - s_done, 1);
    chk("post_rst_rx", cnt_rx[0] - s_rx, 1);

    // randomized traffic with stray data_ready strobes
    spur_en = 1; rnd_dly = 1;
    hold[0] = bit'($urandom_range(0, 1)); hold[1] = bit'($urandom_range(0, 1));
    s_done = cnt_done[0] + cnt_done[1];
    jobs[0] = 25; jobs[1] = 25;
    wait_quiet("random_complete", 40000);
    chk("random_dones", cnt_done[0] + cnt_done[1] - s_done, 50);
    chk("random_mosi_drained", exp_mosi.size(), 0);
    chk("random_miso_drained", miso_sent.size(), 0);
    chk("invariants_random", inv_err, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
